// File: rtl/rv32v_uop_seq.sv
// rtl/rv32v_uop_seq.sv - vector micro-op sequencer: splits one instruction into lane-wide uops
module rv32v_uop_seq #(
    parameter int VLANE_COUNT      = 4,
    parameter int VREG_WIDTH_BYTES = 16,
    parameter int VL_W             = 8
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic                                start,
    input  logic [VL_W-1:0]                     vl,
    input  logic [VL_W-1:0]                     vstart,
    input  logic [1:0]                          veew,
    input  logic                                stall,
    input  logic                                flush,
    output logic                                busy,
    output logic                                uop_valid,
    output logic [VL_W-1:0]                     vuop_num,
    output logic                                vuop_last,
    output logic [2:0]                          vreg_offset,
    output logic [$clog2(VREG_WIDTH_BYTES)-1:0] vbyte_offset,
    output logic [VLANE_COUNT-1:0]              vlane_active,
    output logic                                done
);

    localparam int LS = $clog2(VLANE_COUNT);
    localparam int BW = $clog2(VREG_WIDTH_BYTES);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [VL_W:0] STEP = (VL_W+1)'(VLANE_COUNT);

    logic [0:0]      state_q, state_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [VL_W-1:0] vstart_q, vstart_d;
    logic [1:0]      veew_q, veew_d;
    logic [VL_W:0]   base_q, base_d;
    logic            done_q, done_d;

    logic            issue;
    logic            last;
    logic [7:0]      reg_shamt;

    assign issue = (state_q == S_ISSUE);
    // One extra bit keeps base+STEP from wrapping near the top of the vl range.
    assign last  = issue && ((base_q + STEP) >= {1'b0, vl_q});

    always_comb begin
        state_d  = state_q;
        vl_d     = vl_q;
        vstart_d = vstart_q;
        veew_d   = veew_q;
        base_d   = base_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush && start) begin
                    vl_d     = vl;
                    vstart_d = vstart;
                    veew_d   = veew;
                    base_d   = ({1'b0, vstart} >> LS) << LS;
                    if ((vstart < vl) && (veew != 2'd3)) begin
                        state_d = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    base_d = base_q + STEP;
                    if (last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            vl_q     <= '0;
            vstart_q <= '0;
            veew_q   <= '0;
            base_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vl_q     <= vl_d;
            vstart_q <= vstart_d;
            veew_q   <= veew_d;
            base_q   <= base_d;
            done_q   <= done_d;
        end
    end

    // Elements per register shrink as EEW grows, so the register index shift does too.
    assign reg_shamt = 8'(BW) - {6'b0, veew_q};

    assign busy         = issue;
    assign uop_valid    = issue;
    assign done         = done_q;
    assign vuop_last    = last;
    assign vuop_num     = issue ? VL_W'(base_q >> LS) : '0;
    assign vreg_offset  = issue ? 3'(base_q >> reg_shamt) : '0;
    assign vbyte_offset = issue ? BW'({2'b00, base_q} << veew_q) : '0;

    always_comb begin
        vlane_active = '0;
        for (int i = 0; i < VLANE_COUNT; i++) begin
            if (issue
                && ((base_q + (VL_W+1)'(i)) >= {1'b0, vstart_q})
                && ((base_q + (VL_W+1)'(i)) <  {1'b0, vl_q})) begin
                vlane_active[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32v_uop_seq.sv
// tb/tb_rv32v_uop_seq.sv - self-checking bench for rv32v_uop_seq (4 lanes, 16-byte registers)
module tb_rv32v_uop_seq;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       start, stall, flush;
    logic [7:0] vl, vstart;
    logic [1:0] veew;
    logic       busy, uop_valid, vuop_last, done;
    logic [7:0] vuop_num;
    logic [2:0] vreg_offset;
    logic [3:0] vbyte_offset;
    logic [3:0] vlane_active;

    int total = 0;
    int bad   = 0;

    rv32v_uop_seq #(.VLANE_COUNT(4), .VREG_WIDTH_BYTES(16), .VL_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .vstart(vstart), .veew(veew),
        .stall(stall), .flush(flush), .busy(busy), .uop_valid(uop_valid),
        .vuop_num(vuop_num), .vuop_last(vuop_last), .vreg_offset(vreg_offset),
        .vbyte_offset(vbyte_offset), .vlane_active(vlane_active), .done(done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_count(input int v, input int s, input int e);
        if (s >= v || e == 3) return 0;
        return (v + 3) / 4 - s / 4;
    endfunction

    function automatic logic [3:0] model_lanes(input int base, input int s, input int v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (base + i >= s) && (base + i < v);
        return r;
    endfunction

    // Runs one instruction; mode 0 no stall, 1 random stall + stray starts, 2 three stalls on uop 1.
    task automatic run_instr(input int v, input int s, input int e, input int mode,
                             output int n_seen, output logic [3:0] lf, output int nf,
                             output logic [3:0] ll, output int vrl, output int vbl);
        int  n, k, scnt, base, mul;
        bit  fin;
        n = model_count(v, s, e);
        mul = 1 << e;
        @(negedge CLK);
        start = 1'b1; vl = 8'(v); vstart = 8'(s); veew = 2'(e); stall = 1'b0;
        @(negedge CLK);
        start = 1'b0; vl = 8'($urandom); vstart = 8'($urandom); veew = 2'($urandom);
        k = 0; scnt = 0; fin = 0; lf = '0; nf = -1; ll = '0; vrl = -1; vbl = -1;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (uop_valid) begin
                chk("busy_issue", busy, 1);
                chk("done_during_issue", done, 0);
                if (k < n) begin
                    base = (s / 4) * 4 + 4 * k;
                    chk("vuop_num", vuop_num, base / 4);
                    chk("vlane_active", vlane_active, model_lanes(base, s, v));
                    chk("vuop_last", vuop_last, (k == n - 1) ? 1 : 0);
                    chk("vreg_offset", vreg_offset, ((base * mul) / 16) % 8);
                    chk("vbyte_offset", vbyte_offset, (base * mul) % 16);
                end else begin
                    chk("extra_uop", 1, 0);
                end
                if (k == 0) begin lf = vlane_active; nf = vuop_num; end
                if (k == n - 1) begin ll = vlane_active; vrl = vreg_offset; vbl = vbyte_offset; end
                stall = 1'b0;
                if (mode == 1) begin
                    stall = ($urandom_range(0, 3) == 0);
                    start = 1'($urandom_range(0, 1));
                    vl = 8'($urandom); vstart = 8'($urandom_range(0, 3));
                end else if (mode == 2 && k == 1 && scnt < 3) begin
                    stall = 1'b1;
                    scnt++;
                end
                if (!stall) k++;
                @(negedge CLK);
            end else begin
                start = 1'b0;
                stall = 1'b0;
                chk("busy_idle", busy, 0);
                chk("done_pulse", done, 1);
                fin = 1;
            end
        end
        if (!fin) chk("uop_timeout", 0, 1);
        n_seen = k;
        start = 1'b0; stall = 1'b0;
        @(negedge CLK);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    typedef struct {
        int         vl, vs, eew, mode, n;
        logic [3:0] lf;
        int         nf;
        logic [3:0] ll;
        int         vrl, vbl;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int         n_seen, nf, vrl, vbl, v, s, e;
        logic [3:0] lf, ll;

        tbl[0] = '{10,   0, 0, 0, 3, 4'b1111,  0, 4'b0011, 0, 8};
        tbl[1] = '{10,   5, 2, 0, 2, 4'b1110,  1, 4'b0011, 2, 0};
        tbl[2] = '{12,   0, 1, 2, 3, 4'b1111,  0, 4'b1111, 1, 0};
        tbl[3] = '{0,    0, 0, 0, 0, 4'b0000,  0, 4'b0000, 0, 0};
        tbl[4] = '{7,    7, 0, 0, 0, 4'b0000,  0, 4'b0000, 0, 0};
        tbl[5] = '{5,    0, 3, 0, 0, 4'b0000,  0, 4'b0000, 0, 0};
        tbl[6] = '{16,   0, 0, 1, 4, 4'b1111,  0, 4'b1111, 0, 12};
        tbl[7] = '{1,    0, 2, 0, 1, 4'b0001,  0, 4'b0001, 0, 0};
        tbl[8] = '{255, 250, 2, 1, 2, 4'b1100, 62, 4'b0111, 7, 0};
        tbl[9] = '{9,    3, 1, 1, 3, 4'b1000,  0, 4'b0001, 1, 0};

        nRST = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
        vl = '0; vstart = '0; veew = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_lanes", vlane_active, 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].vl, tbl[i].vs, tbl[i].eew, tbl[i].mode, n_seen, lf, nf, ll, vrl, vbl);
            chk($sformatf("tbl%0d_count", i), n_seen, tbl[i].n);
            if (tbl[i].n > 0) begin
                chk($sformatf("tbl%0d_first_lanes", i), lf, tbl[i].lf);
                chk($sformatf("tbl%0d_first_num", i), nf, tbl[i].nf);
                chk($sformatf("tbl%0d_last_lanes", i), ll, tbl[i].ll);
                chk($sformatf("tbl%0d_last_vreg", i), vrl, tbl[i].vrl);
                chk($sformatf("tbl%0d_last_vbyte", i), vbl, tbl[i].vbl);
            end
        end

        // Flush during the second uop, with stall also asserted.
        @(negedge CLK);
        start = 1'b1; vl = 8'd16; vstart = 8'd0; veew = 2'd0;
        @(negedge CLK);
        start = 1'b0;
        chk("fl_uop0_valid", uop_valid, 1);
        chk("fl_uop0_num", vuop_num, 0);
        @(negedge CLK);
        chk("fl_uop1_num", vuop_num, 1);
        flush = 1'b1; stall = 1'b1;
        @(negedge CLK);
        flush = 1'b0; stall = 1'b0;
        chk("fl_uop_valid", uop_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_done", done, 0);
        @(negedge CLK);
        chk("fl_done_later", done, 0);
        run_instr(16, 0, 0, 0, n_seen, lf, nf, ll, vrl, vbl);
        chk("fl_restart_count", n_seen, 4);
        chk("fl_restart_first_num", nf, 0);

        // Flush in IDLE beats start.
        @(negedge CLK);
        start = 1'b1; flush = 1'b1; vl = 8'd5; vstart = 8'd0;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("flidle_busy", busy, 0);
        chk("flidle_done", done, 0);

        // Asynchronous reset during the second uop.
        @(negedge CLK);
        start = 1'b1; vl = 8'd16; vstart = 8'd0; veew = 2'd0;
        @(negedge CLK);
        start = 1'b0;
        chk("rs_uop0_num", vuop_num, 0);
        @(negedge CLK);
        chk("rs_uop1_num", vuop_num, 1);
        #2 nRST = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_uop_valid", uop_valid, 0);
        chk("rs_num", vuop_num, 0);
        chk("rs_lanes", vlane_active, 0);
        chk("rs_last", vuop_last, 0);
        chk("rs_done", done, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("rs_post_done", done, 0);
        chk("rs_post_busy", busy, 0);
        @(negedge CLK);
        chk("rs_post_done2", done, 0);

        for (int r = 0; r < 40; r++) begin
            v = $urandom_range(0, 255);
            s = $urandom_range(0, (v + 4 > 255) ? 255 : v + 4);
            e = $urandom_range(0, 3);
            run_instr(v, s, e, 1, n_seen, lf, nf, ll, vrl, vbl);
            chk("rand_count", n_seen, model_count(v, s, e));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
